// File: rtl/iob_cache_axi_pkg.sv
// iob_cache_axi_pkg: AXI encodings, refill FSM states and width helpers shared by the line-fetch engine
package iob_cache_axi_pkg;
  typedef enum logic [1:0] {BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10} axi_burst_t;
  typedef enum logic [1:0] {RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11} axi_resp_t;
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, END = 2'd3} state_t;
  function automatic int w1(input int w);
    return w < 1 ? 1 : w;
  endfunction
  function automatic int min_i(input int a, input int b);
    return a < b ? a : b;
  endfunction
endpackage

// File: rtl/iob_cache_line_beat_addr.sv
// iob_cache_line_beat_addr: burst/beat counters, wrapping beat pointer and araddr composition
module iob_cache_line_beat_addr
  import iob_cache_axi_pkg::*;
#(
  parameter int LINE_W = 27,
  parameter int LINE2BE_W = 2,
  parameter int BE_NBYTES_W = 3,
  parameter int BE_ADDR_W = 32,
  parameter int BURST_BEATS = 4,
  parameter int NUM_BURSTS = 1,
  parameter bit WRAP = 1'b0,
  localparam int PW = w1(LINE2BE_W)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 accept_i,
  input  logic                 ar_hs_i,
  input  logic                 r_hs_i,
  input  logic                 next_burst_i,
  input  logic                 clr_burst_i,
  input  logic [LINE_W-1:0]    addr_i,
  input  logic [PW-1:0]        crit_i,
  output logic [BE_ADDR_W-1:0] araddr_o,
  output logic [PW-1:0]        ptr_o,
  output logic                 in_burst_o,
  output logic                 last_beat_o,
  output logic                 last_burst_o
);
  localparam int LINE_BEATS = 2 ** LINE2BE_W;
  localparam int CW = $clog2(BURST_BEATS) + 1;
  localparam int BW = w1($clog2(NUM_BURSTS));
  localparam logic [PW-1:0] MASK = PW'(LINE_BEATS - 1);
  logic [LINE_W-1:0] addr_q, addr_d;
  logic [PW-1:0] crit_q, crit_d, ptr_q, ptr_d, start;
  logic [BW-1:0] burst_q, burst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic adv;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      addr_q  <= '0;
      crit_q  <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      crit_q  <= crit_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
    end
  end
  // beats past the burst length are swallowed: count saturates and the pointer holds
  always_comb begin
    adv     = r_hs_i && in_burst_o;
    start   = ((PW'(burst_q) << $clog2(BURST_BEATS)) + (WRAP ? crit_q : '0)) & MASK;
    addr_d  = accept_i ? addr_i : addr_q;
    crit_d  = accept_i ? crit_i : crit_q;
    burst_d = clr_burst_i ? '0 : next_burst_i ? burst_q + 1'b1 : burst_q;
    cnt_d   = ar_hs_i ? '0 : adv ? cnt_q + 1'b1 : cnt_q;
    ptr_d   = ar_hs_i ? start : adv ? (ptr_q + 1'b1) & MASK : ptr_q;
  end
  assign in_burst_o   = cnt_q < CW'(BURST_BEATS);
  assign last_beat_o  = cnt_q == CW'(BURST_BEATS - 1);
  assign last_burst_o = burst_q == BW'(NUM_BURSTS - 1);
  assign ptr_o        = ptr_q;
  assign araddr_o     = (BE_ADDR_W'(addr_q) << (LINE2BE_W + BE_NBYTES_W)) | (BE_ADDR_W'(start) << BE_NBYTES_W);
endmodule

// File: rtl/iob_cache_line_fetch_axi.sv
// iob_cache_line_fetch_axi: AXI4 line refill in INCR bursts or one critical-word-first WRAP burst, with bounded retry
module iob_cache_line_fetch_axi
  import iob_cache_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BE_ADDR_W = 32,
  parameter int BE_DATA_W = 64,
  parameter int WORD_OFFSET_W = 3,
  parameter int AXI_ID_W = 1,
  parameter int AXI_ID = 0,
  parameter int AXI_LEN_W = 8,
  parameter int MAX_BURST_LEN = 16,
  parameter int MAX_RETRY = 2,
  parameter int WRAP_EN = 0,
  parameter logic [3:0] CACHE_AXI_CACHE_MODE = 4'b0011,
  localparam int BE_NBYTES_W = $clog2(BE_DATA_W / 8),
  localparam int LINE2BE_W = WORD_OFFSET_W - $clog2(BE_DATA_W / DATA_W),
  localparam int PW = w1(LINE2BE_W)
) (
  input  logic                                    clk_i,
  input  logic                                    reset_n_i,
  input  logic                                    replace_valid_i,
  input  logic [ADDR_W-BE_NBYTES_W-LINE2BE_W-1:0] replace_addr_i,
  input  logic [PW-1:0]                           replace_beat_i,
  output logic                                    replace_o,
  output logic                                    read_valid_o,
  output logic [PW-1:0]                           read_addr_o,
  output logic [BE_DATA_W-1:0]                    read_rdata_o,
  output logic                                    error_o,
  output logic [AXI_ID_W-1:0]                     axi_arid_o,
  output logic [BE_ADDR_W-1:0]                    axi_araddr_o,
  output logic [AXI_LEN_W-1:0]                    axi_arlen_o,
  output logic [2:0]                              axi_arsize_o,
  output logic [1:0]                              axi_arburst_o,
  output logic [1:0]                              axi_arlock_o,
  output logic [3:0]                              axi_arcache_o,
  output logic [2:0]                              axi_arprot_o,
  output logic [3:0]                              axi_arqos_o,
  output logic                                    axi_arvalid_o,
  input  logic                                    axi_arready_i,
  input  logic [AXI_ID_W-1:0]                     axi_rid_i,
  input  logic [BE_DATA_W-1:0]                    axi_rdata_i,
  input  logic [1:0]                              axi_rresp_i,
  input  logic                                    axi_rlast_i,
  input  logic                                    axi_rvalid_i,
  output logic                                    axi_rready_o
);
  localparam int LINE_BEATS = 2 ** LINE2BE_W;
  localparam int BURST_BEATS = min_i(LINE_BEATS, MAX_BURST_LEN);
  localparam int NUM_BURSTS = LINE_BEATS / BURST_BEATS;
  localparam bit WRAP = WRAP_EN != 0 && NUM_BURSTS == 1 && LINE_BEATS >= 2 && LINE_BEATS <= 16;
  localparam int RW = w1($clog2(MAX_RETRY + 1));
  state_t state_q, state_d;
  logic err_q, err_d;
  logic [RW-1:0] retry_q, retry_d;
  logic accept, ar_hs, r_hs, retry, in_burst, last_beat, last_burst, unused_rid;
  assign accept     = state_q == IDLE && replace_valid_i;
  assign ar_hs      = state_q == ADDR && axi_arready_i;
  assign r_hs       = state_q == DATA && axi_rvalid_i;
  assign retry      = state_q == END && err_q && int'(retry_q) < MAX_RETRY;
  assign unused_rid = ^axi_rid_i;
  iob_cache_line_beat_addr #(
    .LINE_W(ADDR_W - BE_NBYTES_W - LINE2BE_W),
    .LINE2BE_W(LINE2BE_W),
    .BE_NBYTES_W(BE_NBYTES_W),
    .BE_ADDR_W(BE_ADDR_W),
    .BURST_BEATS(BURST_BEATS),
    .NUM_BURSTS(NUM_BURSTS),
    .WRAP(WRAP)
  ) u_beat (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .accept_i(accept),
    .ar_hs_i(ar_hs),
    .r_hs_i(r_hs),
    .next_burst_i(r_hs && axi_rlast_i && !last_burst),
    .clr_burst_i(state_q == END),
    .addr_i(replace_addr_i),
    .crit_i(replace_beat_i),
    .araddr_o(axi_araddr_o),
    .ptr_o(read_addr_o),
    .in_burst_o(in_burst),
    .last_beat_o(last_beat),
    .last_burst_o(last_burst)
  );
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      retry_q <= retry_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = replace_valid_i ? ADDR : IDLE;
      ADDR:    state_d = axi_arready_i ? DATA : ADDR;
      DATA:    state_d = (r_hs && axi_rlast_i) ? (last_burst ? END : ADDR) : DATA;
      default: state_d = retry ? ADDR : IDLE;
    endcase
    err_d   = state_q == END ? 1'b0 : (r_hs && (axi_rresp_i != RESP_OKAY || (axi_rlast_i && !last_beat))) ? 1'b1 : err_q;
    retry_d = accept ? '0 : retry ? retry_q + 1'b1 : retry_q;
  end
  always_comb begin
    replace_o     = state_q != IDLE;
    axi_arvalid_o = state_q == ADDR;
    axi_rready_o  = state_q == DATA;
    read_valid_o  = r_hs && in_burst;
    error_o       = state_q == END && err_q && !retry;
  end
  assign read_rdata_o  = axi_rdata_i;
  assign axi_arid_o    = AXI_ID_W'(AXI_ID);
  assign axi_arlen_o   = AXI_LEN_W'(BURST_BEATS - 1);
  assign axi_arsize_o  = 3'(BE_NBYTES_W);
  assign axi_arburst_o = WRAP ? BURST_WRAP : BURST_INCR;
  assign axi_arlock_o  = 2'b00;
  assign axi_arcache_o = CACHE_AXI_CACHE_MODE;
  assign axi_arprot_o  = 3'b000;
  assign axi_arqos_o   = 4'b0000;
endmodule

// File: tb/tb_iob_cache_line_fetch_axi.sv
// tb_iob_cache_line_fetch_axi: three configurations (default, 2-beat bursts, wrap) driven by one bench AXI slave
module tb_iob_cache_line_fetch_axi;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;
  logic [2:0] rv, busy, rdv, err, arid, arvalid, rready;
  logic [26:0] raddr;
  logic [1:0] rbeat;
  logic [2:0][1:0] rda, arburst, arlock;
  logic [2:0][63:0] rdd;
  logic [2:0][31:0] araddr;
  logic [2:0][7:0] arlen;
  logic [2:0][2:0] arsize, arprot;
  logic [2:0][3:0] arcache, arqos;
  logic arready, rvalid, rlast, rid;
  logic [63:0] rdata;
  logic [1:0] rresp;
  int checks = 0, errors = 0;
  int n_ar, nrd, nerr, drop, gap, bad;
  logic [31:0] a0, a1;
  logic [1:0] bst;
  logic [7:0] len;
  logic [63:0] seq;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    iob_cache_line_fetch_axi #(
      .MAX_BURST_LEN(g == 1 ? 2 : 16),
      .MAX_RETRY(g == 0 ? 2 : 1),
      .WRAP_EN(g == 2 ? 1 : 0)
    ) u_dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .replace_valid_i(rv[g]), .replace_addr_i(raddr), .replace_beat_i(rbeat),
      .replace_o(busy[g]), .read_valid_o(rdv[g]), .read_addr_o(rda[g]), .read_rdata_o(rdd[g]), .error_o(err[g]),
      .axi_arid_o(arid[g]), .axi_araddr_o(araddr[g]), .axi_arlen_o(arlen[g]), .axi_arsize_o(arsize[g]),
      .axi_arburst_o(arburst[g]), .axi_arlock_o(arlock[g]), .axi_arcache_o(arcache[g]), .axi_arprot_o(arprot[g]),
      .axi_arqos_o(arqos[g]), .axi_arvalid_o(arvalid[g]), .axi_arready_i(arready),
      .axi_rid_i(rid), .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rlast_i(rlast), .axi_rvalid_i(rvalid),
      .axi_rready_o(rready[g])
    );
  end
  typedef struct {
    int d; logic [26:0] line; logic [1:0] crit; logic [15:0] mask; int nb;
    int n_ar; logic [31:0] a0; logic [31:0] a1; logic [1:0] bst; logic [7:0] len;
    int nrd; logic [63:0] seq; int nerr; int gap;
  } vec_t;
  vec_t tv [10];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask
  // mask bit k forces SLVERR on the k-th beat sent; nb overrides the beat count of the first burst
  task automatic run(input int d, input logic [26:0] line, input logic [1:0] crit, input logic [15:0] mask, input int nb);
    int left, k, last_rl, first_rl;
    bit done;
    n_ar = 0; nrd = 0; nerr = 0; seq = '0; bad = 0; drop = -1; gap = -1;
    a0 = '0; a1 = '0; bst = '0; len = '0;
    left = 0; k = 0; last_rl = -100; first_rl = -1; done = 0;
    @(negedge clk);
    raddr = line; rbeat = crit; rv[d] = 1'b1;
    @(negedge clk);
    rv[d] = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      rvalid = left > 0;
      rlast = left == 1;
      rresp = (left > 0 && k < 16 && mask[k]) ? 2'b10 : 2'b00;
      rdata = {32'hcafe0000, 32'(k)};
      rid = ~rid;
      arready = 1'b1;
      #1;
      if (!busy[d]) begin
        drop = c - last_rl;
        done = 1;
      end else begin
        if (err[d]) nerr++;
        if (arvalid[d]) begin
          if (n_ar == 0) a0 = araddr[d];
          if (n_ar == 1) begin a1 = araddr[d]; gap = c - first_rl; end
          bst = arburst[d];
          len = arlen[d];
          if (arsize[d] != 3'd3 || arcache[d] != 4'b0011 || arid[d] != 1'b0 || arlock[d] != 2'b0 || arprot[d] != 3'b0 || arqos[d] != 4'b0) bad++;
          n_ar++;
          left = (n_ar == 1 && nb != 0) ? nb : int'(arlen[d]) + 1;
        end else if (rvalid && rready[d]) begin
          if (rdv[d]) begin
            seq |= 64'(rda[d]) << (4 * nrd);
            nrd++;
            if (rdd[d] !== rdata) bad++;
          end
          if (rlast) begin
            if (first_rl < 0) first_rl = c;
            last_rl = c;
          end
          k++;
          left--;
        end
      end
      @(negedge clk);
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; arready = 1'b0;
  endtask
  initial begin
    int left, ar_seen;
    rv = '0; raddr = '0; rbeat = '0; arready = 0; rvalid = 0; rlast = 0; rresp = 0; rdata = '0; rid = 0;
    tv[0] = '{0, 27'h1234, 2'd0, 16'h0000, 0, 1, 32'h00024680, 32'h0, 2'b01, 8'd3, 4, 64'h3210, 0, -1};
    tv[1] = '{1, 27'h0abc, 2'd0, 16'h0000, 0, 2, 32'h00015780, 32'h00015790, 2'b01, 8'd1, 4, 64'h3210, 0, 1};
    tv[2] = '{2, 27'h1234, 2'd2, 16'h0000, 0, 1, 32'h00024690, 32'h0, 2'b10, 8'd3, 4, 64'h1032, 0, -1};
    tv[3] = '{2, 27'h0000, 2'd3, 16'h0000, 0, 1, 32'h00000018, 32'h0, 2'b10, 8'd3, 4, 64'h2103, 0, -1};
    tv[4] = '{0, 27'h0055, 2'd0, 16'h0002, 0, 2, 32'h00000aa0, 32'h00000aa0, 2'b01, 8'd3, 8, 64'h32103210, 0, 2};
    tv[5] = '{2, 27'h0f0f, 2'd1, 16'hffff, 0, 2, 32'h0001e1e8, 32'h0001e1e8, 2'b10, 8'd3, 8, 64'h03210321, 1, 2};
    tv[6] = '{0, 27'h7ffffff, 2'd0, 16'hffff, 0, 3, 32'hffffffe0, 32'hffffffe0, 2'b01, 8'd3, 12, 64'h321032103210, 1, 2};
    tv[7] = '{1, 27'h0abc, 2'd0, 16'h0004, 0, 4, 32'h00015780, 32'h00015790, 2'b01, 8'd1, 8, 64'h32103210, 0, 1};
    tv[8] = '{0, 27'h0010, 2'd0, 16'h0000, 3, 2, 32'h00000200, 32'h00000200, 2'b01, 8'd3, 7, 64'h3210210, 0, 2};
    tv[9] = '{0, 27'h0011, 2'd0, 16'h0000, 5, 2, 32'h00000220, 32'h00000220, 2'b01, 8'd3, 8, 64'h32103210, 0, 2};
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++)
      chk($sformatf("reset d%0d", d), {busy[d], rdv[d], err[d], arvalid[d], rready[d], rda[d]}, '0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run(tv[i].d, tv[i].line, tv[i].crit, tv[i].mask, tv[i].nb);
      chk($sformatf("v%0d n_ar", i), n_ar, tv[i].n_ar);
      chk($sformatf("v%0d araddr0", i), a0, tv[i].a0);
      chk($sformatf("v%0d araddr1", i), a1, tv[i].a1);
      chk($sformatf("v%0d arburst", i), bst, tv[i].bst);
      chk($sformatf("v%0d arlen", i), len, tv[i].len);
      chk($sformatf("v%0d beats", i), nrd, tv[i].nrd);
      chk($sformatf("v%0d beat_seq", i), seq, tv[i].seq);
      chk($sformatf("v%0d error_pulses", i), nerr, tv[i].nerr);
      chk($sformatf("v%0d ar_gap", i), gap, tv[i].gap);
      chk($sformatf("v%0d busy_drop", i), drop, 2);
      chk($sformatf("v%0d ar_const_rdata", i), bad, 0);
    end
    // abandon a transfer inside the second burst, then refetch from burst 0
    @(negedge clk);
    raddr = 27'h0abc; rbeat = '0; rv[1] = 1'b1;
    @(negedge clk);
    rv[1] = 1'b0;
    left = 0; ar_seen = 0;
    for (int c = 0; c < 40 && !(rready[1] && ar_seen == 2); c++) begin
      rvalid = left > 0; rlast = left == 1; rresp = 2'b00; arready = 1'b1;
      #1;
      if (arvalid[1]) begin ar_seen++; left = 2; end
      else if (rvalid) left--;
      @(negedge clk);
    end
    chk("pre_reset_rready", {rready[1], 8'(ar_seen)}, {1'b1, 8'd2});
    rvalid = 1'b1; rlast = 1'b0; arready = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk("reset_mid_data", {busy[1], rdv[1], err[1], arvalid[1], rready[1], rda[1]}, '0);
    rvalid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    run(1, 27'h0abc, 2'd0, 16'h0000, 0);
    chk("post_reset araddr0", a0, 32'h00015780);
    chk("post_reset n_ar", n_ar, 2);
    chk("post_reset beat_seq", seq, 64'h3210);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
